// File: rtl/eth_pkg.sv
// Shared definitions for the UDP/IPv4 GMII transmit path.
// States, protocol constants and the byte-wide reflected CRC-32 step.
package eth_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_PREAMBLE,
    S_ETH_HDR,
    S_IP_HDR,
    S_UDP_HDR,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IPG
  } tx_state_e;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] MIN_PAYLOAD   = 16'd18;
  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;

  function automatic logic [31:0] crc32_next(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_udp_tx_gmii_crc32_d8.sv
// Byte-wide Ethernet CRC-32, reflected, preset to all ones on init.
// Result is available the cycle after the enabled byte.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= '1;
    else if (init) crc <= '1;
    else if (en)   crc <= crc32_next(crc, d);
  end

endmodule

// File: rtl/eth_udp_tx_gmii.sv
// UDP/IPv4 frame transmitter onto an 8-bit GMII TX port.
// Define ETH_UDP_TX_IPID_INC_EN to increment the IPv4 ID per frame.
module eth_udp_tx_gmii
  import eth_pkg::*;
#(
  parameter int         IPG_CYCLES = 12,
  parameter logic [7:0] TTL        = 8'h40,
  parameter int         MAX_LEN    = 1472
) (
  input  logic        gmii_rx_clk,
  input  logic        reset_n,
  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [15:0] local_port,
  input  logic [47:0] dst_mac,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [15:0] tx_data_length,
  input  logic        tx_go,
  output logic        payload_req_o,
  input  logic [7:0]  payload_dat_i,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err,
  output logic        gmii_txen,
  output logic [7:0]  gmii_txd
);

  tx_state_e   state, nstate;
  logic [15:0] cnt, ncnt;

  logic [47:0] dst_mac_q, src_mac_q;
  logic [31:0] dst_ip_q, src_ip_q;
  logic [15:0] dst_port_q, src_port_q, len_q;
  logic [15:0] tot_len, udp_len, pad_len, ip_csum, ip_id;
  logic        ipg_last, accept, too_long;

  logic [7:0]   byte_d;
  logic         txen_d, crc_en, crc_init;
  logic [31:0]  crc, fcs;
  logic [111:0] eth_hdr;
  logic [159:0] ip_hdr;
  logic [63:0]  udp_hdr;
  logic [15:0]  tot_len_c;
  logic [31:0]  sum;
  logic [16:0]  fold;

  // A go in the cycle busy drops is swallowed via ipg_last
  assign too_long = tx_data_length > 16'(MAX_LEN);
  assign accept   = (state == S_IDLE) && tx_go && !ipg_last && !too_long;

  assign tot_len_c = len_q + IP_HDR_LEN + UDP_HDR_LEN;
  assign sum = 32'h4500 + {16'h0, tot_len_c} + {16'h0, ip_id}
             + 32'h4000 + {16'h0, TTL, IP_PROTO_UDP}
             + {16'h0, src_ip_q[31:16]} + {16'h0, src_ip_q[15:0]}
             + {16'h0, dst_ip_q[31:16]} + {16'h0, dst_ip_q[15:0]};
  assign fold = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};

  assign eth_hdr = {dst_mac_q, src_mac_q, ETH_TYPE_IPV4};
  assign ip_hdr  = {8'h45, 8'h00, tot_len, ip_id, 16'h4000,
                    TTL, IP_PROTO_UDP, ip_csum, src_ip_q, dst_ip_q};
  assign udp_hdr = {src_port_q, dst_port_q, udp_len, 16'h0000};
  assign fcs     = ~crc;

  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt + 16'd1;
    unique case (state)
      S_IDLE: begin
        ncnt = '0;
        if (accept) nstate = S_LATCH;
      end
      S_LATCH: begin
        nstate = S_PREAMBLE;
        ncnt   = 16'd1;
      end
      S_PREAMBLE: if (cnt == 16'd7) begin
        nstate = S_ETH_HDR;
        ncnt   = '0;
      end
      S_ETH_HDR: if (cnt == 16'd13) begin
        nstate = S_IP_HDR;
        ncnt   = '0;
      end
      S_IP_HDR: if (cnt == IP_HDR_LEN - 16'd1) begin
        nstate = S_UDP_HDR;
        ncnt   = '0;
      end
      S_UDP_HDR: if (cnt == UDP_HDR_LEN - 16'd1) begin
        nstate = (len_q != '0) ? S_DATA : S_PAD;
        ncnt   = '0;
      end
      S_DATA: if (cnt == len_q - 16'd1) begin
        nstate = (len_q < MIN_PAYLOAD) ? S_PAD : S_FCS;
        ncnt   = '0;
      end
      S_PAD: if (cnt == pad_len - 16'd1) begin
        nstate = S_FCS;
        ncnt   = '0;
      end
      S_FCS: if (cnt == 16'd3) begin
        nstate = S_IPG;
        ncnt   = '0;
      end
      S_IPG: if (cnt == 16'(IPG_CYCLES)) begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // byte_d is the value gmii_txd takes on the next edge
  always_comb begin
    byte_d   = 8'h00;
    txen_d   = 1'b0;
    crc_en   = 1'b0;
    crc_init = 1'b0;
    payload_req_o = (nstate == S_DATA);
    unique case (state)
      S_LATCH: begin
        txen_d = 1'b1;
        byte_d = PREAMBLE_BYTE;
      end
      S_PREAMBLE: begin
        txen_d   = 1'b1;
        crc_init = (cnt == 16'd7);
        byte_d   = (cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
      end
      S_ETH_HDR: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
        byte_d = eth_hdr[{4'd13 - cnt[3:0], 3'b000} +: 8];
      end
      S_IP_HDR: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
        byte_d = ip_hdr[{5'd19 - cnt[4:0], 3'b000} +: 8];
      end
      S_UDP_HDR: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
        byte_d = udp_hdr[{3'd7 - cnt[2:0], 3'b000} +: 8];
      end
      S_DATA: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
        byte_d = payload_dat_i;
      end
      S_PAD: begin
        txen_d = 1'b1;
        crc_en = 1'b1;
      end
      S_FCS: begin
        txen_d = 1'b1;
        byte_d = fcs[{cnt[1:0], 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  crc32_d8 u_crc (
    .clk     (gmii_rx_clk),
    .reset_n (reset_n),
    .init    (crc_init),
    .en      (crc_en),
    .d       (byte_d),
    .crc     (crc)
  );

  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_mac_q  <= '0;
      src_mac_q  <= '0;
      dst_ip_q   <= '0;
      src_ip_q   <= '0;
      dst_port_q <= '0;
      src_port_q <= '0;
      len_q      <= '0;
      tot_len    <= '0;
      udp_len    <= '0;
      pad_len    <= '0;
      ip_csum    <= '0;
    end else if (accept) begin
      dst_mac_q  <= dst_mac;
      src_mac_q  <= local_mac;
      dst_ip_q   <= dst_ip;
      src_ip_q   <= local_ip;
      dst_port_q <= dst_port;
      src_port_q <= local_port;
      len_q      <= tx_data_length;
    end else if (state == S_LATCH) begin
      tot_len <= tot_len_c;
      udp_len <= len_q + UDP_HDR_LEN;
      pad_len <= MIN_PAYLOAD - len_q;
      ip_csum <= ~(fold[15:0] + {15'h0, fold[16]});
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      gmii_txen <= 1'b0;
      gmii_txd  <= 8'h00;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      ipg_last  <= 1'b0;
    end else begin
      gmii_txen <= txen_d;
      gmii_txd  <= byte_d;
      tx_busy   <= (nstate != S_IDLE);
      tx_done   <= (state == S_IPG) && (cnt == '0);
      tx_err    <= (state == S_IDLE) && tx_go && !ipg_last && too_long;
      ipg_last  <= (state == S_IPG) && (cnt == 16'(IPG_CYCLES));
    end
  end

`ifdef ETH_UDP_TX_IPID_INC_EN
  always_ff @(posedge gmii_rx_clk or negedge reset_n) begin
    if (!reset_n)                           ip_id <= '0;
    else if (state == S_IPG && cnt == '0)   ip_id <= ip_id + 16'd1;
  end
`else
  assign ip_id = 16'h0000;
`endif

endmodule

// File: tb/tb_eth_udp_tx_gmii.sv
// Scoreboard bench for eth_udp_tx_gmii: expected frames are queued
// by the stimulus and compared byte by byte by a GMII monitor.
`timescale 1ns/1ps
module tb_eth_udp_tx_gmii;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [47:0] local_mac = 48'h02_00_00_00_00_02;
  logic [31:0] local_ip  = 32'hC0A8_0002;
  logic [15:0] local_port = 16'd8080;
  logic [47:0] dst_mac = 48'h00_11_22_33_44_55;
  logic [31:0] dst_ip  = 32'hC0A8_0064;
  logic [15:0] dst_port = 16'd5000;
  logic [15:0] tx_data_length = '0;
  logic        tx_go = 1'b0;
  logic        payload_req_o;
  logic [7:0]  payload_dat_i = '0;
  logic        tx_busy, tx_done, tx_err, gmii_txen;
  logic [7:0]  gmii_txd;

  eth_udp_tx_gmii dut (
    .gmii_rx_clk    (clk),
    .reset_n        (reset_n),
    .local_mac      (local_mac),
    .local_ip       (local_ip),
    .local_port     (local_port),
    .dst_mac        (dst_mac),
    .dst_ip         (dst_ip),
    .dst_port       (dst_port),
    .tx_data_length (tx_data_length),
    .tx_go          (tx_go),
    .payload_req_o  (payload_req_o),
    .payload_dat_i  (payload_dat_i),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_err         (tx_err),
    .gmii_txen      (gmii_txen),
    .gmii_txd       (gmii_txd)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int exp_len[$];
  logic [7:0] cap[0:2047];
  int blen = 0, last_blen = 0;
  logic [31:0] rcrc = 32'hFFFFFFFF;
  logic prev_txen = 0, prev_req = 0, req_s = 0;
  int req_cnt = 0, req_runs = 0, done_cnt = 0, err_cnt = 0;
  int done_cyc = 0, fall_cyc = 0, last_gap = 0;
  int pidx = 0;
  logic [15:0] model_id = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 13 + 5);
  endfunction

  function automatic logic [31:0] crc8(input logic [31:0] c,
                                       input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] csum(input logic [15:0] tl,
                                       input logic [15:0] id);
    logic [15:0] w[10];
    int s;
    w = '{16'h4500, tl, id, 16'h4000, 16'h4011, 16'h0000,
          local_ip[31:16], local_ip[15:0], dst_ip[31:16], dst_ip[15:0]};
    s = 0;
    foreach (w[i]) s += int'(w[i]);
    while ((s >> 16) != 0) s = (s & 'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  task automatic push16(inout logic [7:0] f[$], input logic [15:0] v);
    f.push_back(v[15:8]);
    f.push_back(v[7:0]);
  endtask

  task automatic build_frame(input int n, input logic [15:0] id,
                             input int base);
    logic [7:0] f[$];
    logic [31:0] c;
    logic [15:0] tl;
    tl = 16'(n + 28);
    for (int i = 5; i >= 0; i--) f.push_back(dst_mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) f.push_back(local_mac[8*i +: 8]);
    push16(f, 16'h0800);
    push16(f, 16'h4500);
    push16(f, tl);
    push16(f, id);
    push16(f, 16'h4000);
    push16(f, 16'h4011);
    push16(f, csum(tl, id));
    push16(f, local_ip[31:16]);
    push16(f, local_ip[15:0]);
    push16(f, dst_ip[31:16]);
    push16(f, dst_ip[15:0]);
    push16(f, local_port);
    push16(f, dst_port);
    push16(f, 16'(n + 8));
    push16(f, 16'h0000);
    for (int k = 0; k < n; k++) f.push_back(pat(base + k));
    for (int k = n; k < 18; k++) f.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (f[i]) c = crc8(c, f[i]);
    c = ~c;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (f[i]) exp_q.push_back(f[i]);
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    exp_len.push_back(8 + f.size() + 4);
  endtask

  task automatic bump_id();
`ifdef ETH_UDP_TX_IPID_INC_EN
    model_id = model_id + 16'd1;
`endif
  endtask

  task automatic wait_busy(input logic lvl, input string nm);
    int k;
    k = 0;
    while (tx_busy !== lvl && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (tx_busy !== lvl) chk(nm, {31'h0, tx_busy}, {31'h0, lvl});
  endtask

  task automatic send(input int n);
    int d0, fc;
    build_frame(n, model_id, 0);
    bump_id();
    tx_data_length = 16'(n);
    pidx = 0;
    req_cnt = 0;
    req_runs = 0;
    d0 = done_cnt;
    @(negedge clk) tx_go = 1'b1;
    @(negedge clk) tx_go = 1'b0;
    chk("busy_rise", {31'h0, tx_busy}, 1);
    chk("txen_latch", {31'h0, gmii_txen}, 0);
    @(negedge clk);
    chk("first_pre", {23'h0, gmii_txen, gmii_txd}, 32'h155);
    wait_busy(1'b0, "busy_timeout");
    fc = cyc;
    chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    chk("req_count", 32'(req_cnt), 32'(n));
    chk("req_runs", 32'(req_runs), (n > 0) ? 1 : 0);
    chk("ipg_len", 32'(fc - done_cyc), 12);
  endtask

  // Payload FIFO: a byte is presented the cycle after each request
  initial forever begin
    @(negedge clk) req_s = payload_req_o;
    @(posedge clk);
    #1;
    if (req_s) begin
      payload_dat_i = pat(pidx);
      pidx++;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (!reset_n) begin
      prev_txen = 0;
      prev_req = 0;
      blen = 0;
      rcrc = 32'hFFFFFFFF;
    end else begin
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (tx_err) err_cnt++;
      if (payload_req_o) begin
        req_cnt++;
        if (!prev_req) req_runs++;
      end
      prev_req = payload_req_o;
      if (gmii_txen) begin
        if (!prev_txen) last_gap = cyc - fall_cyc;
        if (exp_q.size() == 0) begin
          chk("extra_byte", {24'h0, gmii_txd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("txd_byte", {24'h0, gmii_txd}, {24'h0, e});
        end
        if (blen >= 8) rcrc = crc8(rcrc, gmii_txd);
        if (blen < 2048) cap[blen] = gmii_txd;
        blen++;
      end else if (prev_txen) begin
        fall_cyc = cyc;
        last_blen = blen;
        if (exp_len.size() == 0) chk("extra_frame", 32'(blen), 0);
        else chk("txen_len", 32'(blen), 32'(exp_len.pop_front()));
        chk("residue", ~rcrc, 32'h2144DF1C);
        chk("done_at_fall", {31'h0, tx_done}, 1);
        blen = 0;
        rcrc = 32'hFFFFFFFF;
      end
      prev_txen = gmii_txen;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, k;
    repeat (3) @(negedge clk);
    chk("rst_txen", {31'h0, gmii_txen}, 0);
    chk("rst_txd", {24'h0, gmii_txd}, 0);
    chk("rst_req", {31'h0, payload_req_o}, 0);
    chk("rst_flags", {29'h0, tx_busy, tx_done, tx_err}, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);

    send(64);
    chk("len_118", 32'(last_blen), 118);
    chk("total_len_64", {16'h0, cap[24], cap[25]}, 32'h005C);
    chk("ip_csum_64", {16'h0, cap[32], cap[33]}, 32'hB8DA);
    chk("udp_len_64", {16'h0, cap[46], cap[47]}, 32'h0048);

    send(5);
    chk("len_n5", 32'(last_blen), 72);
    chk("total_len_5", {16'h0, cap[24], cap[25]}, 32'h0021);
    chk("pad_n5", {24'h0, cap[55] | cap[62] | cap[67]}, 0);

    send(0);
    chk("len_n0", 32'(last_blen), 72);

    tx_data_length = 16'd1473;
    e0 = err_cnt;
    @(negedge clk) tx_go = 1'b1;
    @(negedge clk) tx_go = 1'b0;
    chk("err_pulse", {31'h0, tx_err}, 1);
    chk("err_busy", {31'h0, tx_busy}, 0);
    @(negedge clk);
    chk("err_once", {31'h0, tx_err}, 0);
    repeat (4) @(negedge clk);
    chk("err_txen", {30'h0, gmii_txen, tx_busy}, 0);
    chk("err_count", 32'(err_cnt), 32'(e0 + 1));

    build_frame(64, model_id, 0);
    tx_data_length = 16'd64;
    pidx = 0;
    req_cnt = 0;
    d0 = done_cnt;
    @(negedge clk) tx_go = 1'b1;
    @(negedge clk) tx_go = 1'b0;
    k = 0;
    while (req_cnt < 10 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_data", {31'h0, req_cnt >= 10}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_txen", {31'h0, gmii_txen}, 0);
    chk("midrst_busy", {31'h0, tx_busy}, 0);
    exp_q.delete();
    exp_len.delete();
    model_id = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(d0));

    build_frame(20, model_id, 0);
    bump_id();
    build_frame(20, model_id, 20);
    bump_id();
    tx_data_length = 16'd20;
    pidx = 0;
    req_cnt = 0;
    req_runs = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk) tx_go = 1'b1;
    wait_busy(1'b1, "b2b_rise1");
    wait_busy(1'b0, "b2b_fall1");
    chk("b2b_id0", {16'h0, cap[26], cap[27]}, 0);
    wait_busy(1'b1, "b2b_rise2");
    tx_go = 1'b0;
    wait_busy(1'b0, "b2b_fall2");
    chk("b2b_gap", 32'(last_gap), 15);
`ifdef ETH_UDP_TX_IPID_INC_EN
    chk("b2b_id1", {16'h0, cap[26], cap[27]}, 32'h0001);
`else
    chk("b2b_id1", {16'h0, cap[26], cap[27]}, 32'h0000);
`endif
    chk("b2b_done", 32'(done_cnt), 32'(d0 + 2));
    chk("b2b_req", 32'(req_cnt), 40);
    chk("b2b_runs", 32'(req_runs), 2);
    chk("b2b_no_err", 32'(err_cnt), 32'(e0));

    repeat (5) @(negedge clk);
    chk("leftover", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_udp_tx_gmii.md
# eth_udp_tx_gmii

UDP/IPv4 frame transmitter driving an 8-bit GMII transmit interface; the transmit counterpart of the UDP receive path. On a start pulse it emits preamble/SFD, Ethernet II header, IPv4 header with computed checksum, UDP header, payload fetched byte-by-byte from an upstream FIFO, zero padding to minimum frame size, and FCS, followed by an inter-frame gap. It sits between the payload FIFO and the RGMII/GMII output adapter.

## Interface
- IPG_CYCLES, 12: idle cycles enforced after the last FCS byte.
- TTL, 8'h40: IPv4 TTL field.
- MAX_LEN, 1472: largest accepted payload length, in bytes.
- gmii_rx_clk  in  1  125 MHz clock; the TX path runs on this clock.
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock gmii_rx_clk.
- local_mac / local_ip / local_port  in  48/32/16  source addressing.
- dst_mac / dst_ip / dst_port  in  48/32/16  destination addressing.
- tx_data_length  in  16  payload byte count N.
- tx_go  in  1  start pulse, one cycle.
- payload_req_o  out  1  payload byte read strobe.
- payload_dat_i  in  8  payload byte, valid the cycle after each payload_req_o.
- tx_busy  out  1  high from tx_go acceptance through the end of the IPG.
- tx_done  out  1  one-cycle pulse at the end of the frame.
- tx_err  out  1  one-cycle pulse when a request is rejected.
- gmii_txen  out  1  GMII transmit enable.
- gmii_txd  out  8  GMII transmit data.

## Operation
- States: IDLE, LATCH, PREAMBLE (7×55 then D5), ETH_HDR (14), IP_HDR (20), UDP_HDR (8), DATA (N), PAD (18−N when N<18), FCS (4), IPG (IPG_CYCLES).
- IDLE: when tx_go=1 and tx_busy=0, go to LATCH and register all address and length inputs. If tx_data_length>MAX_LEN, pulse tx_err, stay in IDLE, and keep busy low.
- LATCH: one cycle. Compute total_len=N+28, udp_len=N+8, and the IPv4 header checksum. All are 16-bit values; the checksum is the ones'-complement sum with end-around carry, then inverted.
- IPv4 header field values: ver/IHL 45, TOS 00, flags/frag 4000 (DF), protocol 11.
- UDP checksum is transmitted as 0000.
- All multi-byte fields go out MSB-first. EtherType is 0800.
- N=0 is legal: DATA is skipped and 18 pad bytes are sent.
- Pad bytes are 00.
- FCS covers dst MAC through the last pad byte. A receiver running CRC-32 over frame+FCS must reach residue 32'h2144DF1C.
- tx_go while tx_busy=1 is ignored without an error pulse.
- Reset mid-frame: gmii_txen drops at once, the FSM returns to IDLE, and no tx_done is produced.

## Timing
- Reset values: gmii_txen=0, gmii_txd=00, payload_req_o=0, tx_busy=0, tx_done=0, tx_err=0.
- gmii_txd and gmii_txen are registered.
- The first 55 appears 2 cycles after the accepted tx_go.
- tx_busy rises the cycle after tx_go.
- payload_req_o asserts exactly N times, contiguously. The req for byte k precedes that byte on gmii_txd by exactly 2 cycles.
- gmii_txen stays high for 8+14+20+8+max(N,18)+4 = 54+max(N,18) consecutive cycles.
- tx_done pulses in the first cycle with gmii_txen=0.
- tx_busy falls IPG_CYCLES cycles after that. A tx_go in the same cycle tx_busy falls is ignored.

## Configuration
- ETH_UDP_TX_IPID_INC_EN defined: the IPv4 identification field starts at 0000 after reset and increments by 1, wrapping at FFFF, after each completed frame.
- Undefined: the identification field is always 0000.

## Structure
- Shared package eth_pkg: state encodings; constants ETH_TYPE_IPV4=0800, IP_PROTO_UDP=11, PREAMBLE_BYTE=55, SFD_BYTE=D5, MIN_PAYLOAD=18, IP_HDR_LEN=20, UDP_HDR_LEN=8.
- One sub-module: the existing crc32_d8 (init, enable, 1-cycle latency). It is initialised during the SFD and enabled from the first header byte through the last pad byte.
- The IP checksum is computed inline in LATCH.

## Test plan
- N=64, dst 192.168.0.100:5000, src 192.168.0.2:8080 -> 118-cycle txen burst; total_len 005C, udp_len 0048; checksum matches the software model; 64 req pulses; residue 2144DF1C; one tx_done.
- N=5 -> 5 payload bytes, then 13 bytes of 00; total_len 0021; txen high 72 cycles; residue correct.
- N=0 -> no payload_req_o; 18 pad bytes; txen high 72 cycles.
- N=1473 -> one tx_err pulse; tx_busy stays 0; txen stays 0.
- Back-to-back: tx_go held high -> the second frame starts only after 12 idle cycles; with ETH_UDP_TX_IPID_INC_EN the IDs are 0000 then 0001.
- reset_n asserted during DATA -> txen is 0 immediately; no tx_done; the next tx_go yields a clean frame.
